// File: rtl/fibo_bcd_display_if.sv
// Term-display handshake bundle: load/bin from the Fibonacci stage, busy/done and segments back.
interface fibo_bcd_display_if;
    logic       load;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic [6:0] seg_ones;
    logic [6:0] seg_tens;
    logic [6:0] seg_hund;

    modport master (
        output load, bin,
        input  busy, done, seg_ones, seg_tens, seg_hund
    );

    modport slave (
        input  load, bin,
        output busy, done, seg_ones, seg_tens, seg_hund
    );
endinterface

// File: rtl/fibo_bcd_display.sv
// 8-bit binary to 3-digit BCD (8-cycle double dabble) with active-low {g..a} seven-segment drive.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module fibo_bcd_display (
    input  logic              clk,
    input  logic              rst,
    fibo_bcd_display_if.slave bus
);
    localparam int unsigned BIN_W = 8;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned BCD_W = 3 * DIG_W;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic [DIG_W-1:0]   hund;
    logic [DIG_W-1:0]   tens;
    logic [DIG_W-1:0]   ones;

    function automatic logic [DIG_W-1:0] add3(input logic [DIG_W-1:0] n);
        return (n >= DIG_W'(5)) ? n + DIG_W'(3) : n;
    endfunction

    function automatic logic [SEG_W-1:0] seg_of(input logic [DIG_W-1:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Per-nibble correction applied before each shift, no carry between nibbles
    assign adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            hund     <= '0;
            tens     <= '0;
            ones     <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shreg   <= bus.bin;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bus.busy <= 1'b1;
                    scratch  <= {adj[BCD_W-2:0], shreg[BIN_W-1]};
                    shreg    <= {shreg[BIN_W-2:0], 1'b0};
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(7)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hund     <= scratch[11:8];
                    tens     <= scratch[7:4];
                    ones     <= scratch[3:0];
                    bus.done <= 1'b1;
                    // Back-to-back accept keeps throughput at one term per 9 clocks
                    if (bus.load) begin
                        shreg   <= bus.bin;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign bus.seg_hund = (hund == '0) ? SEG_BLANK : seg_of(hund);
    assign bus.seg_tens = ((hund == '0) && (tens == '0)) ? SEG_BLANK : seg_of(tens);
`else
    assign bus.seg_hund = seg_of(hund);
    assign bus.seg_tens = seg_of(tens);
`endif
    assign bus.seg_ones = seg_of(ones);

endmodule
